// File: rtl/sum_squares_if.sv
// sum_squares_if: coordinate-pair in / NBITS result out handshake bundle for sum_squares.
interface sum_squares_if #(parameter int NBITS = 8);
    localparam int W = NBITS / 2;
    logic [W-1:0]     X;
    logic [W-1:0]     Y;
    logic             iValid;
    logic             iReady;
    logic             oValid;
    logic             oReady;
    logic [NBITS-1:0] result;
    modport master (output X, Y, iValid, oReady, input iReady, oValid, result);
    modport slave  (input X, Y, iValid, oReady, output iReady, oValid, result);
endinterface

// File: rtl/sum_squares.sv
// sum_squares: X*X + Y*Y via serial shift-add, feeding the integer sqrt unit.
// Define SUM_SQUARES_SAT_EN to clamp overflow to all ones instead of wrapping.
module sum_squares #(
    parameter int NBITS = 8
) (
    input logic            clock,
    input logic            reset,
    sum_squares_if.slave   bus
);
    localparam int W = NBITS / 2;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, MULX, MULY, DONE} state_t;

    state_t           state, state_d;
    logic [W-1:0]     xr, yr, xr_d, yr_d, op;
    logic [CW-1:0]    cnt, cnt_d;
    logic [NBITS:0]   acc, acc_d, sum;
    logic [NBITS-1:0] res, res_d, red;
    logic             irdy, irdy_d, ovld, ovld_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            cnt   <= '0;
            acc   <= '0;
            res   <= '0;
            irdy  <= 1'b0;
            ovld  <= 1'b0;
        end else begin
            state <= state_d;
            xr    <= xr_d;
            yr    <= yr_d;
            cnt   <= cnt_d;
            acc   <= acc_d;
            res   <= res_d;
            irdy  <= irdy_d;
            ovld  <= ovld_d;
        end
    end

    always_comb begin
        op  = (state == MULX) ? xr : yr;
        sum = acc + (op[cnt] ? ((NBITS+1)'(op) << cnt) : '0);
`ifdef SUM_SQUARES_SAT_EN
        red = sum[NBITS] ? '1 : sum[NBITS-1:0];
`else
        red = sum[NBITS-1:0];
`endif
        state_d = state;
        xr_d    = xr;
        yr_d    = yr;
        cnt_d   = cnt;
        acc_d   = acc;
        res_d   = res;
        irdy_d  = irdy;
        ovld_d  = ovld;
        case (state)
            IDLE: begin
                irdy_d = 1'b1;
                if (bus.iValid && irdy) begin
                    xr_d    = bus.X;
                    yr_d    = bus.Y;
                    acc_d   = '0;
                    cnt_d   = '0;
                    irdy_d  = 1'b0;
                    state_d = MULX;
                end
            end
            MULX: begin
                acc_d   = sum;
                cnt_d   = (cnt == LAST) ? '0 : cnt + 1'b1;
                state_d = (cnt == LAST) ? MULY : MULX;
            end
            MULY: begin
                acc_d = sum;
                cnt_d = (cnt == LAST) ? '0 : cnt + 1'b1;
                if (cnt == LAST) begin
                    res_d   = red;
                    ovld_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                if (ovld && bus.oReady) begin
                    ovld_d  = 1'b0;
                    irdy_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign bus.iReady = irdy;
    assign bus.oValid = ovld;
    assign bus.result = res;
endmodule

// File: tb/tb_sum_squares.sv
// tb_sum_squares: directed + randomized checks of sum_squares against an arithmetic model.
module tb_sum_squares;
    localparam int NBITS = 8;
    localparam int W = NBITS / 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    sum_squares_if #(.NBITS(NBITS)) bus ();
    sum_squares #(.NBITS(NBITS)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model(input int unsigned x, input int unsigned y);
        int unsigned s = x * x + y * y;
`ifdef SUM_SQUARES_SAT_EN
        return (s >= (1 << NBITS)) ? (1 << NBITS) - 1 : s;
`else
        return s % (1 << NBITS);
`endif
    endfunction

    always @(negedge clock)
        if (!reset) chk("ready_valid_exclusive", {31'b0, bus.iReady & bus.oValid}, 0);

    task automatic wait_ready();
        int n = 0;
        while (!bus.iReady && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("iReady_wait", {31'b0, bus.iReady}, 1);
    endtask

    task automatic send(input int unsigned x, input int unsigned y, input int hold, input bit scramble);
        int lat = 0;
        int unsigned exp = model(x, y);
        wait_ready();
        bus.X = W'(x);
        bus.Y = W'(y);
        bus.iValid = 1'b1;
        bus.oReady = (hold == 0);
        @(negedge clock);
        chk("iReady_low_after_accept", {31'b0, bus.iReady}, 0);
        bus.iValid = 1'b0;
        while (!bus.oValid && lat < 40) begin
            if (scramble) begin
                bus.X = W'($urandom);
                bus.Y = W'($urandom);
                bus.iValid = $urandom_range(0, 1) == 1;
            end
            @(negedge clock);
            lat++;
        end
        bus.iValid = 1'b0;
        chk("latency", lat, 2 * W);
        chk("result", {24'b0, bus.result}, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("bp_oValid", {31'b0, bus.oValid}, 1);
            chk("bp_result", {24'b0, bus.result}, exp);
            chk("bp_iReady", {31'b0, bus.iReady}, 0);
        end
        bus.oReady = 1'b1;
        @(negedge clock);
        chk("hs_oValid", {31'b0, bus.oValid}, 0);
        chk("hs_iReady", {31'b0, bus.iReady}, 1);
    endtask

    initial begin
        bus.X = '0;
        bus.Y = '0;
        bus.iValid = 1'b0;
        bus.oReady = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_iReady", {31'b0, bus.iReady}, 0);
        chk("rst_oValid", {31'b0, bus.oValid}, 0);
        chk("rst_result", {24'b0, bus.result}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("release_iReady", {31'b0, bus.iReady}, 1);

        send(3, 4, 0, 0);
        send(15, 15, 0, 0);
        send(0, 0, 0, 0);
        send(15, 0, 0, 0);
        send(5, 12, 10, 0);
        send(6, 8, 0, 1);

        // abort partway through MULY; result still holds 100 from the previous pair
        wait_ready();
        bus.X = 4'd9;
        bus.Y = 4'd7;
        bus.iValid = 1'b1;
        @(negedge clock);
        bus.iValid = 1'b0;
        repeat (6) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_iReady", {31'b0, bus.iReady}, 0);
        chk("async_rst_oValid", {31'b0, bus.oValid}, 0);
        chk("async_rst_result", {24'b0, bus.result}, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_iReady", {31'b0, bus.iReady}, 1);
        send(1, 1, 0, 0);

        for (int i = 0; i < 20; i++)
            send($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
                 $urandom_range(0, 3), $urandom_range(0, 1) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sum_squares.md
Name: sum_squares

Overview:
- Pre-stage directly upstream of the integer square-root unit; together they form a vector-magnitude datapath computing |(X,Y)| = sqrt(X^2 + Y^2).
- Accepts a signed-free (unsigned) coordinate pair and computes X*X + Y*Y with a serial shift-add multiplier.
- Presents the NBITS-wide result on the same iValid/iReady/oValid/oReady handshake the square-root unit consumes.

Parameters:
- NBITS, 8, output width; must match the downstream sqrt NBITS; must be even and >= 4.
- W, NBITS/2 (derived localparam, not overridable), width of each input coordinate.

Ports:
- clock  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- X  input  W  first coordinate, unsigned.
- Y  input  W  second coordinate, unsigned.
- iValid  input  1  upstream presents a valid X/Y pair.
- iReady  output  1  block can accept a pair.
- oValid  output  1  result valid.
- oReady  input  1  downstream can take the result.
- result  output  NBITS  X^2 + Y^2, or saturated/wrapped per optional feature.

Behaviour:
- Interface: one clock `clock`; `reset` is asynchronous and active-high.
- Reset (asynchronous assert, synchronous release): iReady=0, oValid=0, result=0, accumulator=0, bit counter=0, state=IDLE.
- Internal accumulator is NBITS+1 bits wide. Maximum sum is 2*(2^W-1)^2 < 2^(NBITS+1), so the accumulator never overflows internally.
- State machine IDLE -> MULX -> MULY -> DONE -> IDLE.
- IDLE:
  - iReady<=1 (first edge after reset release raises iReady).
  - On an edge with iValid && iReady: latch X and Y, clear accumulator, cnt<=0, iReady<=0, go MULX.
  - Otherwise stay in IDLE.
- MULX (W edges):
  - Each edge: if Xr[cnt]=1, acc <= acc + (Xr << cnt).
  - cnt increments; at cnt==W-1, cnt<=0 and go MULY.
- MULY (W edges):
  - Same shift-add using Yr.
  - At cnt==W-1: result <= final value of acc + last term, oValid<=1, go DONE.
  - Final value is the (NBITS+1)-bit sum, reduced per optional feature.
- DONE:
  - result and oValid hold stable while oReady=0, for unbounded backpressure.
  - On an edge with oValid && oReady: oValid<=0, iReady<=1, go IDLE.
- Latency: input accepted at edge E; oValid rises at edge E+2W.
- Throughput: with oReady tied high, one pair per 2W+2 cycles. The next acceptance is no earlier than the edge after the output handshake.
- X, Y and iValid are ignored outside IDLE. Inputs are sampled only on the accepting edge, so later changes have no effect.
- iReady and oValid are never high simultaneously.
- Zero operands: an all-zero X or Y simply adds nothing. Latency stays fixed at 2W regardless of data.
- Reset mid-operation (any state) aborts immediately to reset values. No partial result is ever presented.

Optional Feature:
- Macro: SUM_SQUARES_SAT_EN.
- Defined: if acc[NBITS]==1, result = all ones (2^NBITS-1); otherwise result = acc[NBITS-1:0]. The downstream sqrt therefore receives a clamped, monotonic input.
- Not defined: result = acc[NBITS-1:0] (modulo 2^NBITS wrap), and the MSB is discarded.
- Handshake and timing are identical in both builds.

Test Plan:
- NBITS=8: X=3, Y=4, oReady=1 -> result=25 with oValid high exactly 8 cycles after the accept edge; iReady returns high on the handshake edge.
- X=15, Y=15 (sum 450) -> result=255 with SUM_SQUARES_SAT_EN defined; result=194 without it.
- X=0, Y=0 -> result=0 with the same 8-cycle latency; X=15, Y=0 -> 225 (no saturation in either build).
- Backpressure: X=5, Y=12, oReady held low 10 cycles -> result=169 and oValid=1 stable throughout, iReady=0; handshake completes on the first oReady=1 edge.
- Input stability: change X/Y and toggle iValid during MULX/MULY -> result still reflects the pair latched at accept (e.g., 6,8 -> 100).
- Reset asserted asynchronously mid-MULY -> iReady, oValid and result go to 0 immediately. After release: iReady=1 on the next edge, and a fresh pair 1,1 -> result=2.
